bnn_dense_sequencer: RTL

Sequencer and accumulator for the single binary dense layer that classifies the received 30×30 image. It runs while the top-level controller holds `bnn_enable` high, after the image buffer is full. For each class it walks all image bytes in the image buffer and the matching weight bytes in the weight ROM, and accumulates XNOR-popcount scores. It then reports the arg-max class back to the controller as `result_ready`/`result_out`.

---
 rtl/bnn_pkg.sv | 37 +++
 rtl/bnn_dense_sequencer_if.sv | 47 ++++
 rtl/xnor_popcount8.sv | 18 +
 rtl/bnn_dense_sequencer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types and constants for the binary dense layer: sequencer states, layer geometry,
// status codes and a byte popcount helper.
package bnn_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDrain,
        StCompare,
        StDone
    } seq_state_t;

    localparam int unsigned IMG_BYTE_SIZE  = 113;
    localparam int unsigned N_CLASSES      = 10;
    localparam int unsigned SCORE_W        = 10;
    localparam int unsigned W_ADDR_W       = 11;
    localparam logic [7:0]  LAST_BYTE_MASK = 8'hF0;

    localparam int unsigned BUF_ADDR_W = 7;
    localparam int unsigned CLASS_W    = 4;

    // Controller-visible status codes shared with the top-level FSM.
    localparam logic [1:0] STATUS_IDLE  = 2'd0;
    localparam logic [1:0] STATUS_BUSY  = 2'd1;
    localparam logic [1:0] STATUS_DONE  = 2'd2;
    localparam logic [1:0] STATUS_ERROR = 2'd3;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bnn_dense_sequencer_if.sv
// Bus bundle between the dense-layer sequencer and its image buffer, weight ROM and controller.
interface bnn_dense_sequencer_if #(
    parameter int unsigned W_ADDR_W = 11,
    parameter int unsigned SCORE_W  = 10
);

    logic                bnn_enable;
    logic                buf_rd_en;
    logic [6:0]          buf_rd_addr;
    logic [7:0]          buf_rd_data;
    logic                w_rd_en;
    logic [W_ADDR_W-1:0] w_rd_addr;
    logic [7:0]          w_rd_data;
    logic                busy;
    logic                result_ready;
    logic [3:0]          result_out;
    logic [SCORE_W-1:0]  result_score;

    modport master (
        input  bnn_enable,
        input  buf_rd_data,
        input  w_rd_data,
        output buf_rd_en,
        output buf_rd_addr,
        output w_rd_en,
        output w_rd_addr,
        output busy,
        output result_ready,
        output result_out,
        output result_score
    );

    modport slave (
        output bnn_enable,
        output buf_rd_data,
        output w_rd_data,
        input  buf_rd_en,
        input  buf_rd_addr,
        input  w_rd_en,
        input  w_rd_addr,
        input  busy,
        input  result_ready,
        input  result_out,
        input  result_score
    );

endinterface

// File: rtl/xnor_popcount8.sv
// Per-byte binary match count: number of equal bit positions between a and b within mask.
module xnor_popcount8
    import bnn_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] mask,
    output logic [3:0] count
);

    logic [7:0] match;

    always_comb begin
        match = ~(a ^ b) & mask;
        count = popcount8(match);
    end

endmodule

// File: rtl/bnn_dense_sequencer.sv
// Walks image and weight bytes once per class, accumulates XNOR-popcount scores and reports the
// arg-max class (ties to the lowest index) to the controller.
module bnn_dense_sequencer
    import bnn_pkg::*;
#(
    parameter int unsigned IMG_BYTE_SIZE  = bnn_pkg::IMG_BYTE_SIZE,
    parameter int unsigned N_CLASSES      = bnn_pkg::N_CLASSES,
    parameter logic [7:0]  LAST_BYTE_MASK = bnn_pkg::LAST_BYTE_MASK,
    parameter int unsigned SCORE_W        = bnn_pkg::SCORE_W,
    parameter int unsigned W_ADDR_W       = bnn_pkg::W_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    bnn_dense_sequencer_if.master    bus
);

    localparam logic [6:0] LastByte  = 7'(IMG_BYTE_SIZE - 1);
    localparam logic [3:0] LastClass = 4'(N_CLASSES - 1);

    seq_state_t          state_q, state_d;
    logic [6:0]          byte_idx_q, byte_idx_d;
    logic [W_ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [3:0]          class_q, class_d;
    logic [SCORE_W-1:0]  acc_q, acc_d;
    logic [SCORE_W-1:0]  best_score_q, best_score_d;
    logic [3:0]          best_class_q, best_class_d;
    // Read data lags issue by one cycle; these remember what the returning byte is.
    logic                pend_q, pend_d;
    logic                pend_last_q, pend_last_d;

    logic [7:0]          term_mask;
    logic [3:0]          term;

    xnor_popcount8 u_xnor_popcount8 (
        .a     (bus.buf_rd_data),
        .b     (bus.w_rd_data),
        .mask  (term_mask),
        .count (term)
    );

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        w_addr_d     = w_addr_q;
        class_d      = class_q;
        acc_d        = acc_q;
        best_score_d = best_score_q;
        best_class_d = best_class_q;
        pend_d       = 1'b0;
        pend_last_d  = 1'b0;
        term_mask    = pend_last_q ? LAST_BYTE_MASK : 8'hFF;

        if (pend_q) begin
            acc_d = acc_q + SCORE_W'(term);
        end

        unique case (state_q)
            StIdle: begin
                if (bus.bnn_enable) begin
                    state_d    = StFetch;
                    byte_idx_d = '0;
                    w_addr_d   = '0;
                    class_d    = '0;
                    acc_d      = '0;
                end
            end
            StFetch: begin
                pend_d      = 1'b1;
                pend_last_d = (byte_idx_q == LastByte);
                w_addr_d    = w_addr_q + W_ADDR_W'(1);
                if (byte_idx_q == LastByte) begin
                    byte_idx_d = '0;
                    state_d    = StDrain;
                end else begin
                    byte_idx_d = byte_idx_q + 7'd1;
                end
            end
            StDrain: begin
                state_d = StCompare;
            end
            StCompare: begin
                if (class_q == '0 || acc_q > best_score_q) begin
                    best_class_d = class_q;
                    best_score_d = acc_q;
                end
                if (class_q == LastClass) begin
                    state_d = StDone;
                end else begin
                    state_d = StFetch;
                    class_d = class_q + 4'd1;
                    acc_d   = '0;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Dropping the enable aborts from any state; no partial result is reported.
        if (state_q != StIdle && !bus.bnn_enable) begin
            state_d     = StIdle;
            pend_d      = 1'b0;
            pend_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            byte_idx_q   <= '0;
            w_addr_q     <= '0;
            class_q      <= '0;
            acc_q        <= '0;
            best_score_q <= '0;
            best_class_q <= '0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            w_addr_q     <= w_addr_d;
            class_q      <= class_d;
            acc_q        <= acc_d;
            best_score_q <= best_score_d;
            best_class_q <= best_class_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
        end
    end

    assign bus.buf_rd_en    = (state_q == StFetch);
    assign bus.w_rd_en      = (state_q == StFetch);
    assign bus.buf_rd_addr  = byte_idx_q;
    assign bus.w_rd_addr    = w_addr_q;
    assign bus.busy         = (state_q != StIdle) && (state_q != StDone);
    assign bus.result_ready = (state_q == StDone);
    assign bus.result_out   = best_class_q;
    assign bus.result_score = best_score_q;

endmodule
